// File: rtl/shifter_ctl.sv
// Sequencing controller for the stream shifter: gates the input handshake, tracks items in flight,
// and applies mask writes through a drain/clear/load sequence. Optional drain timeout: SHIFTER_CTL_TMO_EN.
module shifter_ctl #(
  parameter int DW           = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int DRAIN_TMO    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_start,
  input  logic          i_cmd_stop,
  input  logic          i_cfg_wr,
  input  logic [DW-1:0] i_cfg_wdata,
  input  logic          i_src_valid,
  output logic          o_src_ready,
  output logic          o_sti_valid,
  input  logic          i_sti_ready,
  input  logic          i_sto_valid,
  input  logic          i_sto_ready,
  output logic          o_ctl_ena,
  output logic          o_ctl_clr,
  output logic [DW-1:0] o_cfg_mask,
  output logic          o_busy,
  output logic          o_err_tmo
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CLEAR, LOAD} state_t;

  state_t          r_state, w_state_next;
  state_t          r_ret, w_ret_next;
  logic            r_pend;
  logic [DW-1:0]   r_pend_mask;
  logic [DW-1:0]   r_mask;
  logic [CW-1:0]   r_inflight;
  logic            w_gate;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_tmo_fire;

`ifdef SHIFTER_CTL_TMO_EN
  localparam int TW = $clog2(DRAIN_TMO + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_tmo;

  // The counter restarts whenever DRAIN is not the current state, so every DRAIN entry gets a full window.
  assign w_tmo_fire = (r_state == DRAIN) && (r_inflight != '0) &&
                      (r_tmo_cnt == TW'(DRAIN_TMO - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      if (r_state != DRAIN) r_tmo_cnt <= '0;
      else if (!w_tmo_fire) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_tmo_fire) r_err_tmo <= 1'b1;
    end
  end

  assign o_err_tmo = r_err_tmo;
`else
  assign w_tmo_fire = 1'b0;
  assign o_err_tmo  = 1'b0;
`endif

  assign o_src_ready = i_sti_ready & w_gate;
  assign o_sti_valid = i_src_valid & w_gate;
  assign w_in_xfer   = o_sti_valid & i_sti_ready;
  assign w_out_xfer  = i_sto_valid & i_sto_ready & (r_inflight != '0);
  assign o_cfg_mask  = r_mask;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ret   <= IDLE;
    end else begin
      r_state <= w_state_next;
      r_ret   <= w_ret_next;
    end
  end

  // A stop seen while draining redirects the exit target in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret;
    unique case (r_state)
      IDLE: begin
        if (r_pend) begin
          w_state_next = CLEAR;
          w_ret_next   = i_cmd_start ? RUN : IDLE;
        end else if (i_cmd_start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (i_cmd_stop) begin
          w_state_next = DRAIN;
          w_ret_next   = IDLE;
        end else if (r_pend) begin
          w_state_next = DRAIN;
          w_ret_next   = RUN;
        end
      end
      DRAIN: begin
        if (i_cmd_stop) w_ret_next = IDLE;
        if (w_tmo_fire) w_state_next = CLEAR;
        else if (r_inflight == '0) w_state_next = r_pend ? CLEAR : w_ret_next;
      end
      CLEAR:   w_state_next = LOAD;
      LOAD:    w_state_next = r_ret;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_gate    = 1'b0;
    o_ctl_ena = 1'b0;
    o_ctl_clr = 1'b0;
    o_busy    = (r_state != IDLE);
    unique case (r_state)
      RUN: begin
        o_ctl_ena = 1'b1;
        w_gate    = (r_inflight < CW'(MAX_INFLIGHT));
      end
      DRAIN:   o_ctl_ena = 1'b1;
      CLEAR:   o_ctl_clr = 1'b1;
      default: ;
    endcase
  end

  // A write landing during LOAD must survive, so the set takes priority over the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend      <= 1'b0;
      r_pend_mask <= '0;
      r_mask      <= '1;
      r_inflight  <= '0;
    end else begin
      if (w_tmo_fire) r_inflight <= '0;
      else if (w_in_xfer && !w_out_xfer) r_inflight <= r_inflight + CW'(1);
      else if (!w_in_xfer && w_out_xfer) r_inflight <= r_inflight - CW'(1);

      if (r_state == LOAD && r_pend) r_mask <= r_pend_mask;

      if (i_cfg_wr) begin
        r_pend      <= 1'b1;
        r_pend_mask <= i_cfg_wdata;
      end else if (r_state == LOAD) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule
